// File: rtl/matrix_op_pkg.sv
// Shared definitions for the matrix operator start/done protocol:
// opcodes, response status codes, dispatcher FSM states and request validation.
package matrix_op_pkg;

  localparam logic [2:0] OP_ADD        = 3'd0;
  localparam logic [2:0] OP_SUB        = 3'd1;
  localparam logic [2:0] OP_SCALAR_MUL = 3'd2;
  localparam logic [2:0] OP_TRANSPOSE  = 3'd3;
  localparam logic [2:0] OP_MUL        = 3'd4;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_OP_ERR  = 2'b01;
  localparam logic [1:0] ST_BAD_REQ = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  localparam int unsigned MAX_DIM_DEFAULT = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } disp_state_e;

  // Both dimensions must lie in 1..max_dim and the opcode must be a known operation.
  function automatic logic req_is_valid(input logic [2:0] op,
                                        input logic [2:0] rows,
                                        input logic [2:0] cols,
                                        input int unsigned max_dim);
    return (rows != 3'd0) && (cols != 3'd0) &&
           (32'(rows) <= max_dim) && (32'(cols) <= max_dim) &&
           (op <= OP_MUL);
  endfunction

endpackage

// File: rtl/op_timeout_counter.sv
// Cycle counter for the WAIT phase; expired flags the last allowed wait cycle.
module op_timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign expired = (count_q == CW'(TIMEOUT - 1));

  // The count saturates at the expiry value so it can never wrap back to zero.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/scalar_op_dispatcher.sv
// Initiator side of the matrix operator start/done protocol: validates a request,
// pulses op_start, waits for done/error under a timeout and returns a response.
module scalar_op_dispatcher
  import matrix_op_pkg::*;
#(
  parameter int unsigned MAX_DIM = MAX_DIM_DEFAULT,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [2:0] req_rows,
  input  logic [2:0] req_cols,
  input  logic [3:0] req_scalar,
  output logic       op_start,
  output logic [2:0] op_code,
  output logic [2:0] op_rows,
  output logic [2:0] op_cols,
  output logic [3:0] op_scalar,
  input  logic       op_done,
  input  logic       op_error,
  input  logic [2:0] op_res_rows,
  input  logic [2:0] op_res_cols,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [1:0] rsp_status,
  output logic [2:0] rsp_rows,
  output logic [2:0] rsp_cols,
  output logic       busy
);

  disp_state_e state_q, state_d;
  logic [2:0]  code_q, code_d;
  logic [2:0]  rows_q, rows_d;
  logic [2:0]  cols_q, cols_d;
  logic [3:0]  scalar_q, scalar_d;
  logic [1:0]  status_q, status_d;
  logic [2:0]  res_rows_q, res_rows_d;
  logic [2:0]  res_cols_q, res_cols_d;
  logic        cnt_clear;
  logic        cnt_enable;
  logic        cnt_expired;

  op_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (cnt_expired)
  );

  // Completion inputs are only looked at in WAIT, so late pulses after a timeout drop out.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    scalar_d   = scalar_q;
    status_d   = status_q;
    res_rows_d = res_rows_q;
    res_cols_d = res_cols_q;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          code_d   = req_op;
          rows_d   = req_rows;
          cols_d   = req_cols;
          scalar_d = req_scalar;
          if (req_is_valid(req_op, req_rows, req_cols, MAX_DIM)) begin
            state_d = S_ISSUE;
          end else begin
            state_d    = S_RESP;
            status_d   = ST_BAD_REQ;
            res_rows_d = 3'd0;
            res_cols_d = 3'd0;
          end
        end
      end
      S_ISSUE: begin
        cnt_clear = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (op_error) begin
          state_d    = S_RESP;
          status_d   = ST_OP_ERR;
          res_rows_d = 3'd0;
          res_cols_d = 3'd0;
        end else if (op_done) begin
          state_d    = S_RESP;
          status_d   = ST_OK;
          res_rows_d = op_res_rows;
          res_cols_d = op_res_cols;
        end else if (cnt_expired) begin
          state_d    = S_RESP;
          status_d   = ST_TIMEOUT;
          res_rows_d = 3'd0;
          res_cols_d = 3'd0;
        end else begin
          cnt_enable = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      code_q     <= 3'd0;
      rows_q     <= 3'd0;
      cols_q     <= 3'd0;
      scalar_q   <= 4'd0;
      status_q   <= ST_OK;
      res_rows_q <= 3'd0;
      res_cols_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      scalar_q   <= scalar_d;
      status_q   <= status_d;
      res_rows_q <= res_rows_d;
      res_cols_q <= res_cols_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign op_start   = (state_q == S_ISSUE);
  assign rsp_valid  = (state_q == S_RESP);
  assign op_code    = code_q;
  assign op_rows    = rows_q;
  assign op_cols    = cols_q;
  assign op_scalar  = scalar_q;
  assign rsp_status = status_q;
  assign rsp_rows   = res_rows_q;
  assign rsp_cols   = res_cols_q;

endmodule

// File: tb/tb_scalar_op_dispatcher.sv
// Directed self-checking bench for scalar_op_dispatcher with TIMEOUT=8, MAX_DIM=5.
module tb_scalar_op_dispatcher;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [2:0] req_rows;
  logic [2:0] req_cols;
  logic [3:0] req_scalar;
  logic       op_start;
  logic [2:0] op_code;
  logic [2:0] op_rows;
  logic [2:0] op_cols;
  logic [3:0] op_scalar;
  logic       op_done;
  logic       op_error;
  logic [2:0] op_res_rows;
  logic [2:0] op_res_cols;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_status;
  logic [2:0] rsp_rows;
  logic [2:0] rsp_cols;
  logic       busy;

  int checks;
  int failures;
  int startCount;

  scalar_op_dispatcher #(
    .MAX_DIM (5),
    .TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_rows    (req_rows),
    .req_cols    (req_cols),
    .req_scalar  (req_scalar),
    .op_start    (op_start),
    .op_code     (op_code),
    .op_rows     (op_rows),
    .op_cols     (op_cols),
    .op_scalar   (op_scalar),
    .op_done     (op_done),
    .op_error    (op_error),
    .op_res_rows (op_res_rows),
    .op_res_cols (op_res_cols),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_status  (rsp_status),
    .rsp_rows    (rsp_rows),
    .rsp_cols    (rsp_cols),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts every cycle op_start is high, so stray or stretched pulses show up in the total.
  always @(negedge clk) begin
    if (rst_n && op_start) startCount++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] rows,
                               input logic [2:0] cols, input logic [3:0] scalar);
    req_valid  = 1'b1;
    req_op     = op;
    req_rows   = rows;
    req_cols   = cols;
    req_scalar = scalar;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResponse(input string tag, input logic [1:0] status,
                               input logic [2:0] rows, input logic [2:0] cols);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    checkOutput({tag, "_status"}, 32'(rsp_status), 32'(status));
    checkOutput({tag, "_rows"}, 32'(rsp_rows), 32'(rows));
    checkOutput({tag, "_cols"}, 32'(rsp_cols), 32'(cols));
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
    checkOutput({tag, "_idle_rsp_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    startCount  = 0;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_op      = 3'd0;
    req_rows    = 3'd0;
    req_cols    = 3'd0;
    req_scalar  = 4'd0;
    op_done     = 1'b0;
    op_error    = 1'b0;
    op_res_rows = 3'd0;
    op_res_cols = 3'd0;
    rsp_ready   = 1'b0;

    $display("[TB] reset values");
    #12;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_op_start", 32'(op_start), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_op_code", 32'(op_code), 32'd0);
    checkOutput("rst_rsp_status", 32'(rsp_status), 32'd0);
    tick();
    rst_n = 1'b1;

    $display("[TB] good request op=2 3x4 scalar=7");
    applyStimulus(3'd2, 3'd3, 3'd4, 4'd7);
    tick();
    req_valid = 1'b0;
    checkOutput("good_op_start", 32'(op_start), 32'd1);
    checkOutput("good_op_code", 32'(op_code), 32'd2);
    checkOutput("good_op_rows", 32'(op_rows), 32'd3);
    checkOutput("good_op_cols", 32'(op_cols), 32'd4);
    checkOutput("good_op_scalar", 32'(op_scalar), 32'd7);
    checkOutput("good_busy", 32'(busy), 32'd1);
    checkOutput("good_req_ready", 32'(req_ready), 32'd0);
    tick();
    checkOutput("good_start_one_cycle", 32'(op_start), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput("good_wait_no_rsp", 32'(rsp_valid), 32'd0);
    end
    op_done     = 1'b1;
    op_res_rows = 3'd3;
    op_res_cols = 3'd4;
    tick();
    op_done = 1'b0;
    checkResponse("good", 2'b00, 3'd3, 3'd4);
    handshake("good");

    $display("[TB] bad requests");
    applyStimulus(3'd2, 3'd0, 3'd3, 4'd1);
    tick();
    req_valid = 1'b0;
    checkOutput("bad_rows0_start", 32'(op_start), 32'd0);
    checkOutput("bad_rows0_op_cols", 32'(op_cols), 32'd3);
    checkResponse("bad_rows0", 2'b10, 3'd0, 3'd0);
    handshake("bad_rows0");
    applyStimulus(3'd1, 3'd2, 3'd6, 4'd1);
    tick();
    req_valid = 1'b0;
    checkOutput("bad_cols6_start", 32'(op_start), 32'd0);
    checkResponse("bad_cols6", 2'b10, 3'd0, 3'd0);
    handshake("bad_cols6");
    applyStimulus(3'd6, 3'd2, 3'd2, 4'd1);
    tick();
    req_valid = 1'b0;
    checkOutput("bad_op6_start", 32'(op_start), 32'd0);
    checkResponse("bad_op6", 2'b10, 3'd0, 3'd0);
    handshake("bad_op6");
    checkOutput("bad_start_total", 32'(startCount), 32'd1);

    $display("[TB] timeout with silent operator");
    applyStimulus(3'd0, 3'd2, 3'd2, 4'd0);
    tick();
    req_valid = 1'b0;
    checkOutput("to_op_start", 32'(op_start), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("to_wait_no_rsp", 32'(rsp_valid), 32'd0);
    end
    tick();
    checkResponse("to", 2'b11, 3'd0, 3'd0);
    op_done     = 1'b1;
    op_res_rows = 3'd5;
    op_res_cols = 3'd5;
    tick();
    op_done = 1'b0;
    checkResponse("to_late_done_resp", 2'b11, 3'd0, 3'd0);
    handshake("to");
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
    checkOutput("to_late_done_idle_busy", 32'(busy), 32'd0);
    checkOutput("to_late_done_idle_rsp", 32'(rsp_valid), 32'd0);
    checkOutput("to_late_done_idle_start", 32'(op_start), 32'd0);

    $display("[TB] error wins over done");
    applyStimulus(3'd1, 3'd1, 3'd2, 4'd3);
    tick();
    req_valid = 1'b0;
    tick();
    op_done     = 1'b1;
    op_error    = 1'b1;
    op_res_rows = 3'd2;
    op_res_cols = 3'd2;
    tick();
    op_done  = 1'b0;
    op_error = 1'b0;
    checkResponse("prio_err", 2'b01, 3'd0, 3'd0);
    handshake("prio_err");

    $display("[TB] done in final timeout cycle, then backpressure");
    applyStimulus(3'd3, 3'd2, 3'd3, 4'd1);
    tick();
    req_valid   = 1'b0;
    op_done     = 1'b1;
    op_res_rows = 3'd1;
    op_res_cols = 3'd1;
    tick();
    op_done = 1'b0;
    checkOutput("prio_issue_done_ignored", 32'(rsp_valid), 32'd0);
    for (int i = 1; i < 8; i++) tick();
    checkOutput("prio_last_wait_cycle", 32'(rsp_valid), 32'd0);
    op_done     = 1'b1;
    op_res_rows = 3'd4;
    op_res_cols = 3'd1;
    tick();
    op_done = 1'b0;
    checkResponse("prio_done_at_expiry", 2'b00, 3'd4, 3'd1);
    applyStimulus(3'd4, 3'd5, 3'd5, 4'd15);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkResponse("bp_hold", 2'b00, 3'd4, 3'd1);
      checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
      checkOutput("bp_busy", 32'(busy), 32'd1);
      checkOutput("bp_op_code_held", 32'(op_code), 32'd3);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("bp_after_hs_ready", 32'(req_ready), 32'd1);
    checkOutput("bp_after_hs_start", 32'(op_start), 32'd0);
    tick();
    req_valid = 1'b0;
    checkOutput("bp_next_start", 32'(op_start), 32'd1);
    checkOutput("bp_next_op_code", 32'(op_code), 32'd4);
    checkOutput("bp_next_op_rows", 32'(op_rows), 32'd5);
    checkOutput("bp_next_op_scalar", 32'(op_scalar), 32'd15);

    $display("[TB] asynchronous reset in WAIT");
    tick();
    tick();
    checkOutput("rstw_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstw_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rstw_busy", 32'(busy), 32'd0);
    checkOutput("rstw_op_start", 32'(op_start), 32'd0);
    checkOutput("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rstw_op_code", 32'(op_code), 32'd0);
    checkOutput("rstw_op_rows", 32'(op_rows), 32'd0);
    checkOutput("rstw_op_cols", 32'(op_cols), 32'd0);
    checkOutput("rstw_op_scalar", 32'(op_scalar), 32'd0);
    checkOutput("rstw_rsp_status", 32'(rsp_status), 32'd0);
    checkOutput("rstw_rsp_rows", 32'(rsp_rows), 32'd0);
    checkOutput("rstw_rsp_cols", 32'(rsp_cols), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("rstw_no_restart", 32'(op_start), 32'd0);
    checkOutput("rstw_idle_busy", 32'(busy), 32'd0);
    applyStimulus(3'd1, 3'd1, 3'd1, 4'd0);
    tick();
    req_valid = 1'b0;
    checkOutput("fresh_op_start", 32'(op_start), 32'd1);
    tick();
    op_done     = 1'b1;
    op_res_rows = 3'd1;
    op_res_cols = 3'd1;
    tick();
    op_done = 1'b0;
    checkResponse("fresh", 2'b00, 3'd1, 3'd1);
    handshake("fresh");
    checkOutput("total_start_pulses", 32'(startCount), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scalar_op_dispatcher.md
# scalar_op_dispatcher

- Initiator side of the matrix operator start/done protocol.
- Accepts an operation request (opcode, matrix A dimensions, scalar) over a valid/ready port and validates it.
- Issues a one-cycle start pulse to the operator, waits for done/error under a timeout, then returns a status plus the result dimensions over a valid/ready response port.
- Sits between the UI/command decoder and the operator.

## Interface
Parameters:
- MAX_DIM, 5, largest legal row/column count (legal range 1..MAX_DIM)
- TIMEOUT, 255, cycles allowed in WAIT before timeout (1..255)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  dispatcher can accept a request
- req_op  in  3  opcode
- req_rows  in  3  matrix A rows
- req_cols  in  3  matrix A columns
- req_scalar  in  4  scalar operand
- op_start  out  1  one-cycle start pulse to operator
- op_code  out  3  registered opcode
- op_rows  out  3  registered rows
- op_cols  out  3  registered columns
- op_scalar  out  4  registered scalar
- op_done  in  1  operator completed
- op_error  in  1  operator reports an error
- op_res_rows  in  3  result rows, valid with op_done
- op_res_cols  in  3  result columns, valid with op_done
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes the response
- rsp_status  out  2  00 OK, 01 OP_ERR, 10 BAD_REQ, 11 TIMEOUT
- rsp_rows  out  3  result rows (0 unless OK)
- rsp_cols  out  3  result columns (0 unless OK)
- busy  out  1  state is not IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid&&req_ready, register op/rows/cols/scalar into the op_* outputs.
  - If rows or cols is 0 or >MAX_DIM, or opcode >3'd4: go to RESP with status BAD_REQ and rows/cols 0.
  - Otherwise go to ISSUE.
- **ISSUE**
  - op_start=1 for exactly this cycle.
  - Clear the timeout counter.
  - Next state is WAIT.
  - op_done/op_error are ignored in this cycle.
- **WAIT**
  - Priority 1: op_error → RESP, status OP_ERR.
  - Priority 2: op_done → RESP, status OK, capture op_res_rows/op_res_cols.
  - Priority 3: count==TIMEOUT-1 → RESP, status TIMEOUT.
  - Otherwise increment the counter.
  - op_error wins over a simultaneous op_done.
  - Either op_error or op_done wins over a timeout expiring in the same cycle.
- **RESP**
  - rsp_valid=1; rsp_status/rsp_rows/rsp_cols are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE.
  - No new request is accepted in the handshake cycle.
- op_code/op_rows/op_cols/op_scalar stay stable from ISSUE until the next accepted request.
- done/error pulses seen in IDLE or RESP are ignored (late completion after a timeout is dropped).
- Reset mid-operation returns to IDLE immediately. No op_start is reissued.

## Timing
- Reset values:
  - state IDLE, so req_ready=1 and busy=0.
  - op_start=0, rsp_valid=0.
  - op_code, op_rows, op_cols, op_scalar all 0.
  - rsp_status=00, rsp_rows=0, rsp_cols=0.
- Request accepted at edge N → op_start high in cycle N+1 → WAIT from cycle N+2.
- op_done sampled high at edge M in WAIT → rsp_valid high in cycle M+1.
- Bad request accepted at edge N → rsp_valid high in cycle N+1. No op_start is issued.
- Timeout: with no done/error, rsp_valid rises exactly TIMEOUT cycles after the first WAIT cycle.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Throughput: at most one request per (3 + operator latency + response wait) cycles.

## Structure
- Shared package `matrix_op_pkg`:
  - opcode constants (ADD, SUB, SCALAR_MUL, TRANSPOSE, MUL = 0..4)
  - status codes (ST_OK, ST_OP_ERR, ST_BAD_REQ, ST_TIMEOUT)
  - FSM state enum
  - MAX_DIM default
- One sub-module: `op_timeout_counter`.
  - Inputs: clear, enable.
  - Output: `expired` when count reaches TIMEOUT-1.
  - Width $clog2(TIMEOUT+1).
- Request validation is a combinational function in the package.

## Test plan
- Good request: req op=2, rows=3, cols=4, scalar=7.
  - op_start is one cycle wide and op_* match the request.
  - op_done with res 3x4 after 5 cycles → rsp OK, 3x4 exactly one cycle later.
- Bad requests: rows=0, then cols=6, then op=3'd6.
  - Each gives rsp BAD_REQ with rows/cols 0.
  - op_start never asserts.
- Timeout: TIMEOUT=8, operator silent.
  - rsp TIMEOUT exactly 8 cycles after WAIT entry.
  - A late op_done in RESP/IDLE is ignored.
- Priority: op_done and op_error high in the same WAIT cycle → OP_ERR.
  - op_done in the final timeout cycle → OK.
- Backpressure: hold rsp_ready low 10 cycles.
  - rsp fields stay stable, req_ready=0, busy=1.
  - A new request is accepted one cycle after the handshake.
- Reset asserted in WAIT: all outputs return to their reset values asynchronously.
  - After release, a fresh request completes normally.
